// File: rtl/aes_decrypt128.sv
// Purpose: iterative AES-128 inverse cipher, one inverse round per clock, on-chip key schedule.
// Latency: 21 edges from accepted start to done; 11 edges when the stored schedule is reused.
// Backpressure: none; start is honoured only in IDLE, requests while busy are dropped.
module aes_decrypt128 #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         reuse_key,
  input  logic [127:0] key_in,
  input  logic [127:0] cipher_in,
  output logic [127:0] plain_out,
  output logic         busy,
  output logic         done
);

  // Round count, key schedule and round counter are all sized for AES-128 only.
  generate
    if (NR != 10) begin : g_nr_check
      $error("aes_decrypt128 supports only NR=10");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, EXPAND, ADDKEY, ROUND, FINAL} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0 naturally).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      r = gmul(r, r);
      r = gmul(r, a);
    end
    return gmul(r, r);
  endfunction

  // Forward byte S-box, shared with the encrypt side; used here only by SubWord.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte n sits at bits [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      src = (((n / 4) - (n % 4) + 4) % 4) * 4 + (n % 4);
      o[127-8*n -: 8] = inv_sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         key_valid_q, key_valid_d;
  logic         done_q, done_d;
  logic [127:0] plain_q, plain_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q [0:10];

  logic         rk_we;
  logic [3:0]   rk_widx;
  logic [3:0]   rd_idx;
  logic [127:0] rk_wdat;
  logic [127:0] rd_key;
  logic [127:0] exp_key;
  logic [127:0] isb_out;
  logic [127:0] round_out;
  logic [127:0] final_out;

  // Single read port on the schedule: previous key while expanding, else the current round key.
  always_comb begin
    rd_idx = cnt_q;
    case (state_q)
      EXPAND:  rd_idx = cnt_q - 4'd1;
      ADDKEY:  rd_idx = 4'd10;
      FINAL:   rd_idx = 4'd0;
      default: rd_idx = cnt_q;
    endcase
  end

  assign rd_key    = rk_q[rd_idx];
  assign exp_key   = expand_step(rd_key, rcon(cnt_q));
  assign isb_out   = inv_shift_sub(st_q);
  assign round_out = inv_mix_columns(isb_out ^ rd_key);
  assign final_out = isb_out ^ rd_key;

  // Sequencer: next state, counter, schedule writes and output updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;
    plain_d     = plain_q;
    ct_d        = ct_q;
    st_d        = st_q;
    rk_we       = 1'b0;
    rk_widx     = cnt_q;
    rk_wdat     = exp_key;
    case (state_q)
      IDLE: begin
        if (start) begin
          ct_d = cipher_in;
          if (reuse_key && key_valid_q) begin
            state_d = ADDKEY;
          end else begin
            // rk[0] is only replaced when a new schedule is built; reuse relies on it.
            state_d     = EXPAND;
            cnt_d       = 4'd1;
            key_valid_d = 1'b0;
            rk_we       = 1'b1;
            rk_widx     = 4'd0;
            rk_wdat     = key_in;
          end
        end
      end
      EXPAND: begin
        rk_we = 1'b1;
        if (cnt_q == 4'd10) begin
          key_valid_d = 1'b1;
          state_d     = ADDKEY;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ADDKEY: begin
        st_d    = ct_q ^ rd_key;
        cnt_d   = 4'(NR - 1);
        state_d = ROUND;
      end
      ROUND: begin
        st_d = round_out;
        if (cnt_q == 4'd1) state_d = FINAL;
        else               cnt_d   = cnt_q - 4'd1;
      end
      FINAL: begin
        plain_d = final_out;
        done_d  = 1'b1;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      plain_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      plain_q     <= plain_d;
    end
  end

  // Datapath registers; contents are meaningless until loaded, so no reset.
  always_ff @(posedge clk) begin
    ct_q <= ct_d;
    st_q <= st_d;
  end

  // Eleven-entry round-key register file, one write per cycle.
  always_ff @(posedge clk) begin
    if (rk_we && !rst) rk_q[rk_widx] <= rk_wdat;
  end

  assign plain_out = plain_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_decrypt128.sv
module tb_aes_decrypt128;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         reuse_key;
  logic [127:0] key_in;
  logic [127:0] cipher_in;
  logic [127:0] plain_out;
  logic         busy;
  logic         done;

  aes_decrypt128 #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reuse_key (reuse_key),
    .key_in    (key_in),
    .cipher_in (cipher_in),
    .plain_out (plain_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_total = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) busy_total <= busy_total + int'(busy);

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc_cyc;
    int           acc_busy;
  } entry_t;

  entry_t     sb[$];
  logic [7:0] sbx [256];

  // ---------------- reference encrypt model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbx[p] = x ^ 8'h63;
    end
    sbx[0] = 8'h63;
  endtask

  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] s, t, m;
    logic [7:0]   a0, a1, a2, a3;
    int           src;
    {w[0], w[1], w[2], w[3]} = key;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbx[tmp[23:16]], sbx[tmp[15:8]], sbx[tmp[7:0]], sbx[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      t = '0;
      for (int n = 0; n < 16; n++) begin
        src = (((n / 4) + (n % 4)) % 4) * 4 + (n % 4);
        t[127-8*n -: 8] = sbx[s[127-8*src -: 8]];
      end
      if (r < 10) begin
        m = '0;
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8];
          a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8];
          a3 = t[103-32*c -: 8];
          m[127-32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          m[119-32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          m[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          m[103-32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
        t = m;
      end
      s = t ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge; it is accepted on the following posedge.
  task automatic start_op(input logic [127:0] key, input logic [127:0] ct, input logic reuse,
                          input logic [127:0] exp_pt, input int exp_lat);
    entry_t e;
    key_in    = key;
    cipher_in = ct;
    reuse_key = reuse;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    reuse_key = 1'b0;
    e.pt       = exp_pt;
    e.lat      = exp_lat;
    e.acc_cyc  = cyc;
    e.acc_busy = busy_total;
    sb.push_back(e);
    check_int("accept_busy", int'(busy), 1);
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare; returns in the done cycle.
  task automatic wait_done(input string tag);
    entry_t e;
    int     k;
    k = 0;
    while (done !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done_within_64_cycles", tag);
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_unexpected_done observed=done expected=no_pending_request", tag);
      return;
    end
    e = sb.pop_front();
    check_vec({tag, "_pt"}, plain_out, e.pt);
    check_int({tag, "_latency"}, cyc - e.acc_cyc, e.lat);
    check_int({tag, "_busy_cycles"}, busy_total - e.acc_busy, e.lat);
    check_int({tag, "_busy_at_done"}, int'(busy), 0);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] k, p, c;
    entry_t       drop;
    bit           reuse;

    build_sbox();
    rst       = 1'b1;
    start     = 1'b0;
    reuse_key = 1'b0;
    key_in    = '0;
    cipher_in = '0;
    repeat (3) @(negedge clk);
    check_vec("reset_plain_out", plain_out, '0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 with full expansion; done must be a single-cycle pulse.
    start_op(K1, C1, 1'b0, P1, 21);
    wait_done("c1");
    @(negedge clk);
    check_int("c1_done_pulse_width", int'(done), 0);

    // FIPS-197 App. B, then reuse of its schedule with a zero key on the bus.
    start_op(K2, C2, 1'b0, P2, 21);
    wait_done("appb");
    @(negedge clk);
    start_op('0, C2, 1'b1, P2, 11);
    wait_done("reuse");

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    start_op(K1, C1, 1'b0, P1, 21);
    repeat (4) @(negedge clk);
    key_in    = K2;
    cipher_in = C2;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    wait_done("midstart");
    start_op(K2, C2, 1'b0, P2, 21);
    wait_done("b2b");
    @(negedge clk);

    // Reset in the 15th busy cycle aborts and invalidates the stored schedule.
    start_op(K1, C1, 1'b0, P1, 21);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drop = sb.pop_back();
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_done", int'(done), 0);
    check_vec("abort_plain_out", plain_out, '0);
    repeat (3) @(negedge clk);
    check_int("abort_no_late_done", int'(done), 0);
    start_op(K2, C2, 1'b1, P2, 21);
    wait_done("reuse_after_abort");
    @(negedge clk);

    // Round trip: encrypt with the reference model, decrypt with the DUT.
    k = '0;
    for (int n = 0; n < 50; n++) begin
      reuse = (n % 2 == 1);
      if (!reuse) k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = enc(k, p);
      if (reuse) start_op({$urandom, $urandom, $urandom, $urandom}, c, 1'b1, p, 11);
      else       start_op(k, c, 1'b0, p, 21);
      wait_done($sformatf("rt%0d", n));
    end

    check_int("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
